// File: rtl/ddr_burst_wr_ctrl_if.sv
// ddr_burst_wr_ctrl_if: sample stream and AXI write-master signals of the burst write controller.
// The controller takes the master modport; the stream source / AXI master side takes slave.
interface ddr_burst_wr_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128,
    parameter int IN_WIDTH   = 8,
    parameter int FIFO_DEPTH = 64
);
    logic                          wr_begin;
    logic [ADDR_WIDTH-1:0]         wr_addr_begin;
    logic [ADDR_WIDTH-1:0]         wr_addr_end;
    logic                          wr_data_valid;
    logic [IN_WIDTH-1:0]           wr_data_in;
    logic                          wr_flush;
    logic                          wr_ready;
    logic                          wr_start;
    logic [ADDR_WIDTH-1:0]         wr_addr;
    logic [7:0]                    wr_len;
    logic [DATA_WIDTH-1:0]         wr_data;
    logic                          wr_req;
    logic                          wr_busy;
    logic [$clog2(FIFO_DEPTH):0]   fifo_level;
    logic                          overflow;
    logic                          underrun;
    modport master (
        input  wr_begin, wr_addr_begin, wr_addr_end, wr_data_valid, wr_data_in, wr_flush, wr_req, wr_busy,
        output wr_ready, wr_start, wr_addr, wr_len, wr_data, fifo_level, overflow, underrun
    );
    modport slave (
        output wr_begin, wr_addr_begin, wr_addr_end, wr_data_valid, wr_data_in, wr_flush, wr_req, wr_busy,
        input  wr_ready, wr_start, wr_addr, wr_len, wr_data, fifo_level, overflow, underrun
    );
endinterface

// File: rtl/ddr_burst_wr_ctrl.sv
// ddr_burst_wr_ctrl: packs narrow samples into AXI words, buffers them in a FWFT FIFO and
// issues ring-addressed write bursts with flush, restart and sticky error flags.
module ddr_burst_wr_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128,
    parameter int IN_WIDTH   = 8,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 64
) (
    input logic clk,
    input logic rst,
    ddr_burst_wr_ctrl_if.master bus
);
    localparam int K = DATA_WIDTH / IN_WIDTH;
    localparam int LNW = $clog2(K);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BSH = $clog2(DATA_WIDTH / 8);
    localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0] BL = (AW + 1)'(BURST_LEN);
    localparam logic [LNW-1:0] LAST = LNW'(K - 1);
    typedef enum logic [1:0] {IDLE, START, BEAT, DONE} state_t;
    state_t state, state_nx;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] pack, cur;
    logic [LNW-1:0] lane;
    logic [AW-1:0] wp, rp;
    logic [AW:0] level;
    logic [ADDR_WIDTH-1:0] addr, addr_nx, room;
    logic [ADDR_WIDTH:0] addr_sum;
    logic [7:0] len, len_nx, cap, beat;
    logic begin_q, pend, apply, drain, ovf, unr, push, wr_en, pop, go, last;
    always_comb begin
        cur = pack;
        if (bus.wr_data_valid) cur[IN_WIDTH*int'(lane) +: IN_WIDTH] = bus.wr_data_in;
        apply = pend && state == IDLE;
        push = !apply && ((bus.wr_data_valid && lane == LAST) ||
                          (bus.wr_flush && (bus.wr_data_valid || lane != '0)));
        pop = state == BEAT && bus.wr_req && level != '0;
        wr_en = push && (level != FULL || pop);
        cap = level >= BL ? 8'(BURST_LEN) : 8'(level);
        // never let a burst run past the ring end
        room = (bus.wr_addr_end - addr) >> BSH;
        len_nx = room < ADDR_WIDTH'(cap) ? room[7:0] : cap;
        addr_sum = {1'b0, addr} + ((ADDR_WIDTH + 1)'(len) << BSH);
        addr_nx = addr_sum >= {1'b0, bus.wr_addr_end} ? bus.wr_addr_begin : addr_sum[ADDR_WIDTH-1:0];
    end
    always_comb begin
        go = !apply && !bus.wr_busy && (level >= BL || (drain && level != '0));
        last = bus.wr_req && beat == len - 8'd1;
        state_nx = state == IDLE ? (go ? START : IDLE)
                 : state == START ? BEAT
                 : state == BEAT ? (last ? DONE : BEAT)
                 : (bus.wr_busy ? DONE : IDLE);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            begin_q <= 1'b0;
            pend <= 1'b0;
            addr <= '0;
            len <= '0;
            beat <= '0;
        end else begin
            state <= state_nx;
            begin_q <= bus.wr_begin;
            pend <= (pend && !apply) || (bus.wr_begin && !begin_q);
            addr <= apply ? bus.wr_addr_begin : state == DONE && !bus.wr_busy ? addr_nx : addr;
            len <= state == IDLE && go ? len_nx : len;
            beat <= state == BEAT ? beat + 8'(bus.wr_req) : '0;
        end
    end
    // a restart clears the datapath but still captures a coincident sample into lane 0
    always_ff @(posedge clk) begin
        if (rst || apply) begin
            lane <= LNW'(!rst && bus.wr_data_valid);
            pack <= !rst && bus.wr_data_valid ? DATA_WIDTH'(bus.wr_data_in) : '0;
            wp <= '0;
            rp <= '0;
            level <= '0;
            drain <= 1'b0;
            ovf <= 1'b0;
            unr <= 1'b0;
        end else begin
            lane <= push ? '0 : lane + LNW'(bus.wr_data_valid);
            pack <= push ? '0 : cur;
            wp <= wp + AW'(wr_en);
            rp <= rp + AW'(pop);
            level <= level + (AW + 1)'(wr_en) - (AW + 1)'(pop);
            drain <= bus.wr_flush && (push || level != '0) ? 1'b1 : level == '0 ? 1'b0 : drain;
            ovf <= ovf || (push && !wr_en);
            unr <= unr || (state == BEAT && bus.wr_req && level == '0);
        end
    end
    always_ff @(posedge clk) if (wr_en) mem[wp] <= cur;
    assign bus.wr_start = state == START;
    assign bus.wr_addr = addr;
    assign bus.wr_len = len;
    assign bus.wr_data = level != '0 ? mem[rp] : '0;
    assign bus.fifo_level = level;
    assign bus.wr_ready = level != FULL;
    assign bus.overflow = ovf;
    assign bus.underrun = unr;
endmodule

// File: tb/tb_ddr_burst_wr_ctrl.sv
// tb_ddr_burst_wr_ctrl: directed streams with a header/data scoreboard checked by an independent monitor,
// plus an AXI-master responder that answers each wr_start with wr_busy and wr_len wr_req beats.
module tb_ddr_burst_wr_ctrl;
    localparam int AW = 32, DW = 128, IW = 8, BL = 16, FD = 64;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    ddr_burst_wr_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IN_WIDTH(IW), .FIFO_DEPTH(FD)) bus ();
    ddr_burst_wr_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IN_WIDTH(IW), .BURST_LEN(BL), .FIFO_DEPTH(FD)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    int n_cmp = 0;
    int n_bad = 0;
    int pops = 0;
    logic [DW-1:0] exp_data[$];
    logic [AW+7:0] exp_hdr[$];
    logic resp_req = 1'b0, stray_req = 1'b0, resp_busy = 1'b0, busy_force = 1'b0;
    logic req_en = 1'b1, abort = 1'b0;
    logic [DW-1:0] m_word = '0;
    int m_lane = 0, m_words = 0;
    logic [15:0] m_idx = '0;
    assign bus.wr_req = resp_req | stray_req;
    assign bus.wr_busy = resp_busy | busy_force;
    task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask
    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic exp_burst(logic [AW-1:0] a, logic [7:0] l);
        exp_hdr.push_back({a, l});
    endtask
    // stream n bytes; byte value = idx[7:0]^idx[15:8]; only the first `limit` words since restart are expected
    task automatic send(int n, int limit);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = m_idx[7:0] ^ m_idx[15:8];
            bus.wr_data_valid = 1'b1;
            bus.wr_data_in = b;
            m_word[m_lane*8 +: 8] = b;
            m_lane++;
            if (m_lane == DW / IW) begin
                if (m_words < limit) exp_data.push_back(m_word);
                m_words++;
                m_word = '0;
                m_lane = 0;
            end
            m_idx++;
            tick(1);
        end
        bus.wr_data_valid = 1'b0;
    endtask
    task automatic flush();
        bus.wr_flush = 1'b1;
        if (m_lane != 0) exp_data.push_back(m_word);
        m_word = '0;
        m_lane = 0;
        tick(1);
        bus.wr_flush = 1'b0;
    endtask
    task automatic restart(logic [AW-1:0] b, logic [AW-1:0] e);
        bus.wr_addr_begin = b;
        bus.wr_addr_end = e;
        bus.wr_begin = 1'b1;
        tick(3);
        bus.wr_begin = 1'b0;
        tick(2);
        m_word = '0;
        m_lane = 0;
        m_words = 0;
        check("restart_addr", bus.wr_addr, b);
    endtask
    task automatic wait_pops(int target, int budget);
        int c = 0;
        while (pops < target && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("pop_count", pops, target);
        tick(4);
    endtask
    task automatic check_queues(string tag);
        check({tag, "_hdr_left"}, exp_hdr.size(), 0);
        check({tag, "_data_left"}, exp_data.size(), 0);
    endtask
    task automatic check_reset_outputs();
        check("rst_wr_start", bus.wr_start, 0);
        check("rst_wr_addr", bus.wr_addr, 0);
        check("rst_wr_len", bus.wr_len, 0);
        check("rst_wr_data", bus.wr_data, 0);
        check("rst_fifo_level", bus.fifo_level, 0);
        check("rst_overflow", bus.overflow, 0);
        check("rst_underrun", bus.underrun, 0);
        check("rst_wr_ready", bus.wr_ready, 1);
    endtask
    // AXI master model
    initial begin
        int n, k;
        forever begin
            @(negedge clk);
            if (bus.wr_start && !rst) begin
                n = int'(bus.wr_len);
                k = 0;
                @(posedge clk);
                #1 resp_busy = 1'b1;
                while (k < n && !abort) begin
                    resp_req = req_en;
                    @(posedge clk);
                    if (resp_req && !rst) begin
                        k++;
                        pops++;
                    end
                    #1;
                end
                resp_req = 1'b0;
                resp_busy = 1'b0;
            end
        end
    end
    // monitor: burst headers and beat data against the scoreboard
    initial begin
        int left;
        left = 0;
        forever begin
            @(negedge clk);
            if (rst) left = 0;
            else begin
                if (bus.wr_start) begin
                    if (exp_hdr.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL burst_hdr: unexpected wr_start addr %0h len %0d", bus.wr_addr, bus.wr_len);
                    end else check("burst_hdr", {bus.wr_addr, bus.wr_len}, exp_hdr.pop_front());
                    left = int'(bus.wr_len);
                end
                if (bus.wr_req && left > 0) begin
                    if (exp_data.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL beat_data: unexpected beat %0h", bus.wr_data);
                    end else check("beat_data", bus.wr_data, exp_data.pop_front());
                    left--;
                end
            end
        end
    end
    initial begin
        #1_000_000;
        n_bad++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
    initial begin
        int t, c;
        bus.wr_begin = 1'b0;
        bus.wr_addr_begin = '0;
        bus.wr_addr_end = '0;
        bus.wr_data_valid = 1'b0;
        bus.wr_data_in = '0;
        bus.wr_flush = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);
        check_reset_outputs();
        // single full burst
        restart(32'h1000, 32'h10000);
        exp_burst(32'h1000, 8'd16);
        t = pops + 16;
        send(256, 1000);
        wait_pops(t, 500);
        check("next_addr_0x1100", bus.wr_addr, 32'h1100);
        check_queues("burst");
        // flush of a partial word, stray wr_req in IDLE
        exp_burst(32'h1100, 8'd2);
        t = pops + 2;
        send(20, 1000);
        tick(2);
        check("flush_level_before", bus.fifo_level, 1);
        stray_req = 1'b1;
        tick(1);
        stray_req = 1'b0;
        tick(1);
        check("stray_req_no_pop", bus.fifo_level, 1);
        check("stray_req_no_underrun", bus.underrun, 0);
        flush();
        wait_pops(t, 200);
        tick(10);
        check("flush_level_after", bus.fifo_level, 0);
        check("flush_wr_data_empty", bus.wr_data, 0);
        check("flush_next_addr", bus.wr_addr, 32'h1120);
        check_queues("flush");
        // ring wrap
        restart(32'h0, 32'h200);
        exp_burst(32'h000, 8'd16);
        exp_burst(32'h100, 8'd16);
        exp_burst(32'h000, 8'd16);
        t = pops + 48;
        send(768, 1000);
        wait_pops(t, 500);
        check("wrap_next_addr", bus.wr_addr, 32'h100);
        check_queues("wrap");
        // overflow: the 65th word is dropped
        restart(32'h0, 32'h10000);
        req_en = 1'b0;
        for (int i = 0; i < 4; i++) exp_burst(AW'(i * 256), 8'd16);
        t = pops + 64;
        send(65 * 16, 64);
        tick(2);
        check("ovf_level", bus.fifo_level, 64);
        check("ovf_flag", bus.overflow, 1);
        check("ovf_wr_ready", bus.wr_ready, 0);
        req_en = 1'b1;
        wait_pops(t, 1000);
        check("ovf_drained_level", bus.fifo_level, 0);
        check("ovf_sticky", bus.overflow, 1);
        check("ovf_next_addr", bus.wr_addr, 32'h400);
        check_queues("ovf");
        // back-pressure by wr_busy, then restart requested mid-BEAT
        restart(32'h2000, 32'h10000);
        check("restart_clears_ovf", bus.overflow, 0);
        busy_force = 1'b1;
        send(256, 1000);
        tick(10);
        check("busy_blocks_start", bus.wr_start, 0);
        check("busy_level", bus.fifo_level, 16);
        req_en = 1'b0;
        exp_burst(32'h2000, 8'd16);
        t = pops + 16;
        busy_force = 1'b0;
        tick(5);
        bus.wr_addr_begin = 32'h3000;
        bus.wr_begin = 1'b1;
        tick(3);
        bus.wr_begin = 1'b0;
        tick(1);
        check("pending_restart_addr", bus.wr_addr, 32'h2000);
        req_en = 1'b1;
        wait_pops(t, 500);
        m_word = '0;
        m_lane = 0;
        m_words = 0;
        check("restart_after_done_addr", bus.wr_addr, 32'h3000);
        check_queues("restart");
        // reset after 5 pops of a burst
        exp_burst(32'h3000, 8'd16);
        t = pops + 5;
        send(256, 1000);
        c = 0;
        while (pops < t && c < 500) begin
            @(negedge clk);
            c++;
        end
        check("pre_reset_pops", pops, t);
        #1;
        rst = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b0;
        abort = 1'b0;
        exp_data.delete();
        exp_hdr.delete();
        tick(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
